sc_shift_collector: RTL and testbench
=====================================

SC_SHIFT_COLLECTOR -- requirements
Module: sc_shift_collector

Interface
REQ-001 SHALL have parameter SHIFTCOLLECTOR_DATAWIDTH, default 8, word width in bits (minimum 2).
REQ-002 SHALL have parameter SHIFTCOLLECTOR_MSBFIRST, default 1. Value 1: first serial bit lands in the MSB. Value 0: first serial bit lands in the LSB.
REQ-003 SC_REGSHIFTER_CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-004 SC_REGSHIFTER_RESET_InHigh  input  1  reset, asynchronous, active-high.
REQ-005 SC_SHIFTCOLLECTOR_clear_InLow  input  1  synchronous clear, active-low.
REQ-006 SC_SHIFTCOLLECTOR_start_InLow  input  1  frame start strobe, active-low.
REQ-007 SC_SHIFTCOLLECTOR_bitvalid_In  input  1  serial bit qualifier, active-high.
REQ-008 SC_SHIFTCOLLECTOR_serial_In  input  1  serial data bit, sampled when bitvalid_In=1.
REQ-009 SC_SHIFTCOLLECTOR_ack_InLow  input  1  consumer acknowledge of a ready word, active-low.
REQ-010 SC_SHIFTCOLLECTOR_data_OutBUS  output  DATAWIDTH  last completed word, registered.
REQ-011 SC_SHIFTCOLLECTOR_dataready_Out  output  1  completed word available, registered.
REQ-012 SC_SHIFTCOLLECTOR_overrun_Out  output  1  sticky flag: a bit arrived while a word was unacknowledged.
REQ-013 SC_SHIFTCOLLECTOR_busy_Out  output  1  high while in COLLECT.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, COLLECT, HOLD.
REQ-015 IDLE: start_InLow=0 -> COLLECT; bit counter and shift register cleared to 0; bitvalid_In ignored in this cycle.
REQ-016 COLLECT: each edge with bitvalid_In=1 shifts serial_In into the shift register and increments the counter; bitvalid_In=0 holds both.
REQ-017 MSBFIRST=1 shift SHALL be {reg[W-2:0], serial_In}; MSBFIRST=0 shift SHALL be {serial_In, reg[W-1:1]}.
REQ-018 The edge sampling bit number W (counter = W-1 with bitvalid_In=1) SHALL, on that same edge: load data_OutBUS with the completed word, set dataready_Out=1, reset the counter to 0, and go to HOLD.
REQ-019 start_InLow=0 in COLLECT SHALL restart the frame: counter=0, shift register=0, the bit in that cycle is discarded, state stays COLLECT.
REQ-020 HOLD: data_OutBUS and dataready_Out SHALL hold until ack_InLow=0. The next edge then sets dataready_Out=0 and moves to IDLE; data_OutBUS keeps its value.
REQ-021 HOLD: bitvalid_In=1 SHALL set overrun_Out=1 and the bit is discarded. start_InLow is ignored in HOLD.
REQ-022 HOLD with ack_InLow=0 and bitvalid_In=1 on the same edge: ack wins, overrun is still set, and the bit is discarded.
REQ-023 overrun_Out SHALL clear only on reset or clear_InLow=0.
REQ-024 clear_InLow=0 SHALL take priority over all other inputs. On the next edge: state=IDLE, counter=0, shift register=0, data_OutBUS=0, dataready_Out=0, overrun_Out=0.
REQ-025 busy_Out SHALL be 1 exactly when state=COLLECT.
REQ-026 The counter SHALL be ceil(log2(W)) bits wide and never exceed W-1.

Reset
REQ-027 SC_REGSHIFTER_RESET_InHigh=1 SHALL immediately (asynchronously) force state=IDLE, counter=0, shift register=0, data_OutBUS=0, dataready_Out=0, overrun_Out=0, busy_Out=0, including mid-frame and in HOLD.
REQ-028 After reset deasserts, the block SHALL wait in IDLE for a new start_InLow=0; no partial frame survives.

Verification
REQ-029 W=8, MSBFIRST=1: start, then bits 1,0,1,0,0,1,0,1 on consecutive edges -> data_OutBUS=0xA5 and dataready_Out=1 at the 8th bit edge; busy_Out=0 afterwards.
REQ-030 W=8, MSBFIRST=0: same bit sequence -> data_OutBUS=0xA5 read LSB-first, i.e. 0xA5 with bit0=first bit; bitvalid_In gaps of 3 cycles between bits give the same result.
REQ-031 After 0xA5 is ready, send 2 more bits before ack -> overrun_Out=1, data_OutBUS stays 0xA5; ack -> dataready_Out=0 next edge, overrun_Out stays 1 until clear_InLow=0.
REQ-032 Send 3 bits, assert start_InLow=0, then send 0x3C MSB-first -> data_OutBUS=0x3C, with no residue from the first 3 bits.
REQ-033 Assert reset after 5 of 8 bits -> all outputs 0 immediately; a subsequent full frame 0xFF yields data_OutBUS=0xFF after exactly 8 bit edges.
REQ-034 clear_InLow=0 during HOLD with ack_InLow=0 in the same cycle -> next edge: IDLE, data_OutBUS=0x00, dataready_Out=0, overrun_Out=0.

Source files
------------

// File: rtl/sc_shift_collector_if.sv
// sc_shift_collector_if
// Groups the control, serial and result signals of the shift collector.
//   master : the producer/consumer side; drives clear, start, bitvalid,
//            serial and ack, and observes the result and status flags.
//   slave  : the collector itself; the exact mirror of master.
// Signals (the names are kept from the existing codebase):
//   SC_SHIFTCOLLECTOR_clear_InLow     synchronous clear, active-low
//   SC_SHIFTCOLLECTOR_start_InLow     frame start strobe, active-low
//   SC_SHIFTCOLLECTOR_bitvalid_In     serial bit qualifier
//   SC_SHIFTCOLLECTOR_serial_In       serial data bit
//   SC_SHIFTCOLLECTOR_ack_InLow       consumer acknowledge, active-low
//   SC_SHIFTCOLLECTOR_data_OutBUS     last completed word
//   SC_SHIFTCOLLECTOR_dataready_Out   completed word available
//   SC_SHIFTCOLLECTOR_overrun_Out     sticky overrun flag
//   SC_SHIFTCOLLECTOR_busy_Out        collecting a frame
interface sc_shift_collector_if #(
    parameter int DATAWIDTH = 8
);
    logic                 SC_SHIFTCOLLECTOR_clear_InLow;
    logic                 SC_SHIFTCOLLECTOR_start_InLow;
    logic                 SC_SHIFTCOLLECTOR_bitvalid_In;
    logic                 SC_SHIFTCOLLECTOR_serial_In;
    logic                 SC_SHIFTCOLLECTOR_ack_InLow;
    logic [DATAWIDTH-1:0] SC_SHIFTCOLLECTOR_data_OutBUS;
    logic                 SC_SHIFTCOLLECTOR_dataready_Out;
    logic                 SC_SHIFTCOLLECTOR_overrun_Out;
    logic                 SC_SHIFTCOLLECTOR_busy_Out;

    modport master (
        output SC_SHIFTCOLLECTOR_clear_InLow,
        output SC_SHIFTCOLLECTOR_start_InLow,
        output SC_SHIFTCOLLECTOR_bitvalid_In,
        output SC_SHIFTCOLLECTOR_serial_In,
        output SC_SHIFTCOLLECTOR_ack_InLow,
        input  SC_SHIFTCOLLECTOR_data_OutBUS,
        input  SC_SHIFTCOLLECTOR_dataready_Out,
        input  SC_SHIFTCOLLECTOR_overrun_Out,
        input  SC_SHIFTCOLLECTOR_busy_Out
    );

    modport slave (
        input  SC_SHIFTCOLLECTOR_clear_InLow,
        input  SC_SHIFTCOLLECTOR_start_InLow,
        input  SC_SHIFTCOLLECTOR_bitvalid_In,
        input  SC_SHIFTCOLLECTOR_serial_In,
        input  SC_SHIFTCOLLECTOR_ack_InLow,
        output SC_SHIFTCOLLECTOR_data_OutBUS,
        output SC_SHIFTCOLLECTOR_dataready_Out,
        output SC_SHIFTCOLLECTOR_overrun_Out,
        output SC_SHIFTCOLLECTOR_busy_Out
    );
endinterface

// File: rtl/sc_shift_collector.sv
// sc_shift_collector
// Collects SHIFTCOLLECTOR_DATAWIDTH qualified serial bits into a word,
// presents it until the consumer acknowledges, and flags bits that arrive
// while a word is still unacknowledged.
// Ports:
//   SC_REGSHIFTER_CLOCK_50      system clock, rising edge
//   SC_REGSHIFTER_RESET_InHigh  asynchronous reset, active-high
//   bus                         sc_shift_collector_if.slave (control in,
//                               word and status flags out, all registered)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start_InLow=0
// COLLECT | shifting in qualified bits, busy_Out=1
// HOLD    | word presented with dataready_Out=1, waiting for ack_InLow=0
module sc_shift_collector #(
    parameter int SHIFTCOLLECTOR_DATAWIDTH = 8,
    parameter int SHIFTCOLLECTOR_MSBFIRST  = 1
) (
    input logic SC_REGSHIFTER_CLOCK_50,
    input logic SC_REGSHIFTER_RESET_InHigh,
    sc_shift_collector_if.slave bus
);
    localparam int W  = SHIFTCOLLECTOR_DATAWIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    generate
        if (W < 2) begin : g_width_check
            $error("sc_shift_collector: SHIFTCOLLECTOR_DATAWIDTH must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [W-1:0]    shift_reg;
    logic [W-1:0]    shift_next;
    logic [W-1:0]    data_reg;
    logic            ready_reg;
    logic            overrun_reg;
    logic            busy_reg;

    generate
        if (SHIFTCOLLECTOR_MSBFIRST != 0) begin : g_msb_first
            always_comb shift_next = {shift_reg[W-2:0], bus.SC_SHIFTCOLLECTOR_serial_In};
        end else begin : g_lsb_first
            always_comb shift_next = {bus.SC_SHIFTCOLLECTOR_serial_In, shift_reg[W-1:1]};
        end
    endgenerate

    always_ff @(posedge SC_REGSHIFTER_CLOCK_50 or posedge SC_REGSHIFTER_RESET_InHigh) begin
        if (SC_REGSHIFTER_RESET_InHigh) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            ready_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else if (!bus.SC_SHIFTCOLLECTOR_clear_InLow) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            ready_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.SC_SHIFTCOLLECTOR_start_InLow) begin
                        state     <= COLLECT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                COLLECT: begin
                    // A start strobe mid-frame restarts it and drops this cycle's bit.
                    if (!bus.SC_SHIFTCOLLECTOR_start_InLow) begin
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end else if (bus.SC_SHIFTCOLLECTOR_bitvalid_In) begin
                        shift_reg <= shift_next;
                        if (bit_cnt == LAST_BIT) begin
                            data_reg  <= shift_next;
                            ready_reg <= 1'b1;
                            bit_cnt   <= '0;
                            busy_reg  <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // Bits arriving here are discarded but remembered as overrun,
                    // even on the acknowledging edge.
                    if (bus.SC_SHIFTCOLLECTOR_bitvalid_In) begin
                        overrun_reg <= 1'b1;
                    end
                    if (!bus.SC_SHIFTCOLLECTOR_ack_InLow) begin
                        ready_reg <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bit_cnt  <= '0;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SC_SHIFTCOLLECTOR_data_OutBUS   = data_reg;
    assign bus.SC_SHIFTCOLLECTOR_dataready_Out = ready_reg;
    assign bus.SC_SHIFTCOLLECTOR_overrun_Out   = overrun_reg;
    assign bus.SC_SHIFTCOLLECTOR_busy_Out      = busy_reg;

endmodule

// File: tb/tb_sc_shift_collector.sv
// tb_sc_shift_collector
// Drives an MSB-first and an LSB-first collector (W=8) from the same
// stimulus and compares both against a frame-level model every cycle.
module tb_sc_shift_collector;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear_n = 1'b1;
    logic start_n = 1'b1;
    logic bitvalid = 1'b0;
    logic serial = 1'b0;
    logic ack_n = 1'b1;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    always #10 clk = ~clk;

    sc_shift_collector_if #(.DATAWIDTH(W)) if_m ();
    sc_shift_collector_if #(.DATAWIDTH(W)) if_l ();

    assign if_m.SC_SHIFTCOLLECTOR_clear_InLow = clear_n;
    assign if_m.SC_SHIFTCOLLECTOR_start_InLow = start_n;
    assign if_m.SC_SHIFTCOLLECTOR_bitvalid_In = bitvalid;
    assign if_m.SC_SHIFTCOLLECTOR_serial_In   = serial;
    assign if_m.SC_SHIFTCOLLECTOR_ack_InLow   = ack_n;
    assign if_l.SC_SHIFTCOLLECTOR_clear_InLow = clear_n;
    assign if_l.SC_SHIFTCOLLECTOR_start_InLow = start_n;
    assign if_l.SC_SHIFTCOLLECTOR_bitvalid_In = bitvalid;
    assign if_l.SC_SHIFTCOLLECTOR_serial_In   = serial;
    assign if_l.SC_SHIFTCOLLECTOR_ack_InLow   = ack_n;

    sc_shift_collector #(.SHIFTCOLLECTOR_DATAWIDTH(W), .SHIFTCOLLECTOR_MSBFIRST(1)) dut_m (
        .SC_REGSHIFTER_CLOCK_50    (clk),
        .SC_REGSHIFTER_RESET_InHigh(rst),
        .bus                       (if_m.slave)
    );

    sc_shift_collector #(.SHIFTCOLLECTOR_DATAWIDTH(W), .SHIFTCOLLECTOR_MSBFIRST(0)) dut_l (
        .SC_REGSHIFTER_CLOCK_50    (clk),
        .SC_REGSHIFTER_RESET_InHigh(rst),
        .bus                       (if_l.slave)
    );

    // Frame-level model: bits collected so far in arrival order.
    localparam int P_IDLE = 0, P_COLLECT = 1, P_HOLD = 2;
    int       m_phase;
    bit       m_bits[$];
    logic [W-1:0] m_data_m, m_data_l;
    logic     m_ready, m_overrun;

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_bits.delete();
        m_data_m  = '0;
        m_data_l  = '0;
        m_ready   = 1'b0;
        m_overrun = 1'b0;
    endtask

    function automatic logic [W-1:0] word_of(bit msb_first);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (msb_first) w[W-1-i] = m_bits[i];
            else           w[i]     = m_bits[i];
        end
        return w;
    endfunction

    task automatic model_step();
        if (!clear_n) begin
            model_reset();
        end else begin
            case (m_phase)
                P_IDLE: if (!start_n) begin
                    m_phase = P_COLLECT;
                    m_bits.delete();
                end
                P_COLLECT: begin
                    if (!start_n) begin
                        m_bits.delete();
                    end else if (bitvalid) begin
                        m_bits.push_back(serial);
                        if (m_bits.size() == W) begin
                            m_data_m = word_of(1'b1);
                            m_data_l = word_of(1'b0);
                            m_ready  = 1'b1;
                            m_phase  = P_HOLD;
                            m_bits.delete();
                        end
                    end
                end
                default: begin
                    if (bitvalid) m_overrun = 1'b1;
                    if (!ack_n) begin
                        m_ready = 1'b0;
                        m_phase = P_IDLE;
                    end
                end
            endcase
        end
    endtask

    task automatic check_bit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_byte(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            check_byte("msb_data",    if_m.SC_SHIFTCOLLECTOR_data_OutBUS,   m_data_m);
            check_bit ("msb_ready",   if_m.SC_SHIFTCOLLECTOR_dataready_Out, m_ready);
            check_bit ("msb_overrun", if_m.SC_SHIFTCOLLECTOR_overrun_Out,   m_overrun);
            check_bit ("msb_busy",    if_m.SC_SHIFTCOLLECTOR_busy_Out,      m_phase == P_COLLECT);
            check_byte("lsb_data",    if_l.SC_SHIFTCOLLECTOR_data_OutBUS,   m_data_l);
            check_bit ("lsb_ready",   if_l.SC_SHIFTCOLLECTOR_dataready_Out, m_ready);
            check_bit ("lsb_overrun", if_l.SC_SHIFTCOLLECTOR_overrun_Out,   m_overrun);
            check_bit ("lsb_busy",    if_l.SC_SHIFTCOLLECTOR_busy_Out,      m_phase == P_COLLECT);
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic idle_inputs();
        clear_n = 1'b1; start_n = 1'b1; bitvalid = 1'b0; serial = 1'b0; ack_n = 1'b1;
    endtask

    task automatic start_frame();
        start_n = 1'b0; tick(); start_n = 1'b1;
    endtask

    task automatic send_bits(logic [W-1:0] value, int nbits, int gap);
        for (int i = 0; i < nbits; i++) begin
            bitvalid = 1'b1;
            serial   = value[W-1-i];
            tick();
            bitvalid = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic do_ack();
        ack_n = 1'b0; tick(); ack_n = 1'b1;
    endtask

    task automatic check_all_zero(string tag);
        check_byte({tag, "_m_data"},  if_m.SC_SHIFTCOLLECTOR_data_OutBUS, 8'h00);
        check_bit ({tag, "_m_ready"}, if_m.SC_SHIFTCOLLECTOR_dataready_Out, 1'b0);
        check_bit ({tag, "_m_ovr"},   if_m.SC_SHIFTCOLLECTOR_overrun_Out, 1'b0);
        check_bit ({tag, "_m_busy"},  if_m.SC_SHIFTCOLLECTOR_busy_Out, 1'b0);
        check_byte({tag, "_l_data"},  if_l.SC_SHIFTCOLLECTOR_data_OutBUS, 8'h00);
        check_bit ({tag, "_l_ready"}, if_l.SC_SHIFTCOLLECTOR_dataready_Out, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        run = 1'b1;
        tick();

        // 1,0,1,0,0,1,0,1 consecutive: 0xA5 either way round.
        start_frame();
        send_bits(8'hA5, 8, 0);
        check_byte("seq_msb_a5", if_m.SC_SHIFTCOLLECTOR_data_OutBUS, 8'hA5);
        check_byte("seq_lsb_a5", if_l.SC_SHIFTCOLLECTOR_data_OutBUS, 8'hA5);
        check_byte("model_a5",   m_data_m, 8'hA5);
        check_bit ("seq_ready",  if_m.SC_SHIFTCOLLECTOR_dataready_Out, 1'b1);
        check_bit ("seq_busy",   if_m.SC_SHIFTCOLLECTOR_busy_Out, 1'b0);
        do_ack();
        check_bit ("ack_ready",  if_m.SC_SHIFTCOLLECTOR_dataready_Out, 1'b0);
        check_byte("ack_keep",   if_m.SC_SHIFTCOLLECTOR_data_OutBUS, 8'hA5);

        // Same frame with 3-cycle gaps.
        start_frame();
        send_bits(8'hA5, 8, 3);
        check_byte("gap_lsb_a5", if_l.SC_SHIFTCOLLECTOR_data_OutBUS, 8'hA5);
        check_byte("gap_msb_a5", if_m.SC_SHIFTCOLLECTOR_data_OutBUS, 8'hA5);

        // Two bits while holding -> sticky overrun.
        send_bits(8'hC0, 2, 0);
        check_bit ("ovr_set",    if_m.SC_SHIFTCOLLECTOR_overrun_Out, 1'b1);
        check_byte("ovr_keep",   if_m.SC_SHIFTCOLLECTOR_data_OutBUS, 8'hA5);
        do_ack();
        check_bit ("ovr_ack_rdy", if_m.SC_SHIFTCOLLECTOR_dataready_Out, 1'b0);
        check_bit ("ovr_sticky",  if_m.SC_SHIFTCOLLECTOR_overrun_Out, 1'b1);
        repeat (3) tick();
        check_bit ("ovr_sticky2", if_l.SC_SHIFTCOLLECTOR_overrun_Out, 1'b1);
        clear_n = 1'b0; tick(); clear_n = 1'b1;
        check_bit ("ovr_clear",   if_m.SC_SHIFTCOLLECTOR_overrun_Out, 1'b0);
        check_byte("clear_data",  if_m.SC_SHIFTCOLLECTOR_data_OutBUS, 8'h00);

        // Restart mid-frame: no residue from the first three bits.
        start_frame();
        send_bits(8'hE0, 3, 0);
        bitvalid = 1'b1; serial = 1'b1; start_frame(); bitvalid = 1'b0;
        send_bits(8'h3C, 8, 0);
        check_byte("restart_msb", if_m.SC_SHIFTCOLLECTOR_data_OutBUS, 8'h3C);
        check_byte("restart_lsb", if_l.SC_SHIFTCOLLECTOR_data_OutBUS, 8'h3C);

        // Ack and bit on the same edge: ack wins, overrun still set.
        ack_n = 1'b0; bitvalid = 1'b1; tick(); ack_n = 1'b1; bitvalid = 1'b0;
        check_bit ("ackbit_rdy",  if_m.SC_SHIFTCOLLECTOR_dataready_Out, 1'b0);
        check_bit ("ackbit_ovr",  if_m.SC_SHIFTCOLLECTOR_overrun_Out, 1'b1);
        clear_n = 1'b0; tick(); clear_n = 1'b1;

        // Asynchronous reset after 5 bits, then a clean 0xFF frame.
        start_frame();
        send_bits(8'hA8, 5, 0);
        #1 rst = 1'b1;
        model_reset();
        #1 check_all_zero("async_rst");
        #1 rst = 1'b0;
        tick();
        check_bit("post_rst_idle", if_m.SC_SHIFTCOLLECTOR_busy_Out, 1'b0);
        start_frame();
        send_bits(8'hFF, 7, 0);
        check_bit ("ff_7_notready", if_m.SC_SHIFTCOLLECTOR_dataready_Out, 1'b0);
        send_bits(8'h80, 1, 0);
        check_bit ("ff_8_ready",    if_m.SC_SHIFTCOLLECTOR_dataready_Out, 1'b1);
        check_byte("ff_8_data",     if_m.SC_SHIFTCOLLECTOR_data_OutBUS, 8'hFF);

        // Clear with ack in the same HOLD cycle.
        bitvalid = 1'b1; tick(); bitvalid = 1'b0;
        clear_n = 1'b0; ack_n = 1'b0; tick(); clear_n = 1'b1; ack_n = 1'b1;
        check_all_zero("clear_ack");

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            clear_n  = ($urandom_range(0, 99) != 0);
            start_n  = ($urandom_range(0, 23) != 0);
            bitvalid = 1'($urandom_range(0, 1));
            serial   = 1'($urandom_range(0, 1));
            ack_n    = ($urandom_range(0, 7) != 0);
            tick();
        end
        idle_inputs();
        tick();

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
